// File: rtl/pc_ir_unit_pkg.sv
// Shared constants for the fetch-side datapath of the multicycle CPU.
// PC source codes, opcodes and instruction field positions.
package pc_ir_unit_pkg;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_BAD    = 2'b11;

    localparam logic [5:0] OP_NOP = 6'b000000;
    localparam logic [5:0] OP_J   = 6'b000001;
    localparam logic [5:0] OP_BEQ = 6'b100000;

    localparam int RS_LSB   = 21;
    localparam int RT_LSB   = 16;
    localparam int RD_LSB   = 11;
    localparam int REG_W    = 5;
    localparam int IMM_W    = 16;
    localparam int JTGT_W   = 26;

endpackage

// File: rtl/pc_ir_unit_en_reg.sv
// Enable-gated register with asynchronous active-low clear.
// Used for the PC, instruction register and memory data register.
module en_reg #(
    parameter int             W       = 32,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            q <= RST_VAL;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/pc_ir_unit.sv
// Program counter, instruction register and memory data register.
// All outputs come straight from registers.
module pc_ir_unit
    import pc_ir_unit_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                OP_W     = 6,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              PCWrite,
    input  logic              PCWriteCond,
    input  logic [1:0]        PCSource,
    input  logic              IRWrite,
    input  logic              Zero,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [DATA_W-1:0] ALUOut,
    input  logic [DATA_W-1:0] MemData,
    output logic [DATA_W-1:0] PC,
    output logic [OP_W-1:0]   Op,
    output logic [REG_W-1:0]  rs,
    output logic [REG_W-1:0]  rt,
    output logic [REG_W-1:0]  rd,
    output logic [IMM_W-1:0]  imm16,
    output logic [DATA_W-1:0] MDR,
    output logic [15:0]       fetch_cnt,
    output logic              pc_src_err
);

    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] mdr_q;
    logic [15:0]       cnt_q;
    logic              err_q;
    logic              pc_ld, pc_en;

    assign pc_ld = PCWrite | (PCWriteCond & Zero);

    // Code 11 is illegal: the PC is left alone and the error is latched instead.
    always_comb begin
        pc_d  = pc_q;
        pc_en = 1'b0;
        case (PCSource)
            PCSRC_ALU: begin
                pc_d  = ALUResult;
                pc_en = pc_ld;
            end
            PCSRC_ALUOUT: begin
                pc_d  = ALUOut;
                pc_en = pc_ld;
            end
            PCSRC_JUMP: begin
                pc_d  = {pc_q[DATA_W-1:JTGT_W], ir_q[JTGT_W-1:0]};
                pc_en = pc_ld;
            end
            default: begin
                pc_d  = pc_q;
                pc_en = 1'b0;
            end
        endcase
    end

    en_reg #(.W(DATA_W), .RST_VAL(RESET_PC)) u_pc (
        .clk   (clk),
        .reset (reset),
        .en    (pc_en),
        .d     (pc_d),
        .q     (pc_q)
    );

    en_reg #(.W(DATA_W)) u_ir (
        .clk   (clk),
        .reset (reset),
        .en    (IRWrite),
        .d     (MemData),
        .q     (ir_q)
    );

    en_reg #(.W(DATA_W)) u_mdr (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .d     (MemData),
        .q     (mdr_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (IRWrite)
                cnt_q <= cnt_q + 16'd1;
            if (pc_ld && PCSource == PCSRC_BAD)
                err_q <= 1'b1;
        end
    end

    assign PC         = pc_q;
    assign Op         = ir_q[DATA_W-1 -: OP_W];
    assign rs         = ir_q[RS_LSB +: REG_W];
    assign rt         = ir_q[RT_LSB +: REG_W];
    assign rd         = ir_q[RD_LSB +: REG_W];
    assign imm16      = ir_q[IMM_W-1:0];
    assign MDR        = mdr_q;
    assign fetch_cnt  = cnt_q;
    assign pc_src_err = err_q;

endmodule

// File: tb/tb_pc_ir_unit.sv
// Directed self-checking bench for pc_ir_unit.
// Expected values are hand-computed constants.
module tb_pc_ir_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCWrite, PCWriteCond, IRWrite, Zero;
    logic [1:0]  PCSource;
    logic [31:0] ALUResult, ALUOut, MemData;
    logic [31:0] PC, MDR;
    logic [5:0]  Op;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16, fetch_cnt;
    logic        pc_src_err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pc_ir_unit dut (
        .clk         (clk),
        .reset       (reset),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .PCSource    (PCSource),
        .IRWrite     (IRWrite),
        .Zero        (Zero),
        .ALUResult   (ALUResult),
        .ALUOut      (ALUOut),
        .MemData     (MemData),
        .PC          (PC),
        .Op          (Op),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .imm16       (imm16),
        .MDR         (MDR),
        .fetch_cnt   (fetch_cnt),
        .pc_src_err  (pc_src_err)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IRWrite     = 1'b0;
        Zero        = 1'b0;
        PCSource    = 2'b00;
        ALUResult   = '0;
        ALUOut      = '0;
        MemData     = 32'hDEADBEEF;

        repeat (3) step();
        check("rst_pc",   PC, 32'h0);
        check("rst_op",   {26'd0, Op}, 32'h0);
        check("rst_mdr",  MDR, 32'h0);
        check("rst_cnt",  {16'd0, fetch_cnt}, 32'h0);
        check("rst_err",  {31'd0, pc_src_err}, 32'h0);

        reset     = 1'b1;
        MemData   = 32'h48221000;
        ALUResult = 32'h1;
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        PCSource  = 2'b00;
        step();
        check("fetch_pc",  PC, 32'h1);
        check("fetch_op",  {26'd0, Op}, 32'h12);
        check("fetch_rs",  {27'd0, rs}, 32'd1);
        check("fetch_rt",  {27'd0, rt}, 32'd2);
        check("fetch_rd",  {27'd0, rd}, 32'd2);
        check("fetch_imm", {16'd0, imm16}, 32'h1000);
        check("fetch_cnt", {16'd0, fetch_cnt}, 32'd1);
        check("fetch_mdr", MDR, 32'h48221000);

        IRWrite = 1'b0;
        PCWrite = 1'b0;
        MemData = 32'h12345678;
        step();
        check("mdr_lat",  MDR, 32'h12345678);
        check("hold_cnt", {16'd0, fetch_cnt}, 32'd1);
        check("hold_op",  {26'd0, Op}, 32'h12);

        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        ALUOut      = 32'h40;
        ALUResult   = 32'h99;
        Zero        = 1'b0;
        step();
        check("beq_nt_pc", PC, 32'h1);
        check("beq_nt_err", {31'd0, pc_src_err}, 32'h0);
        Zero = 1'b1;
        step();
        check("beq_t_pc", PC, 32'h40);

        PCSource = 2'b11;
        Zero     = 1'b0;
        step();
        check("cond_bad_nz", {31'd0, pc_src_err}, 32'h0);
        check("cond_bad_pc", PC, 32'h40);

        PCWriteCond = 1'b0;
        PCWrite     = 1'b1;
        PCSource    = 2'b00;
        ALUResult   = 32'hF0000004;
        MemData     = 32'h04000123;
        IRWrite     = 1'b1;
        step();
        check("pre_j_pc",  PC, 32'hF0000004);
        check("pre_j_op",  {26'd0, Op}, 32'h01);
        check("pre_j_cnt", {16'd0, fetch_cnt}, 32'd2);

        PCSource = 2'b10;
        MemData  = 32'h08000456;
        step();
        check("jump_pc",  PC, 32'hF0000123);
        check("jump_op",  {26'd0, Op}, 32'h02);
        check("jump_cnt", {16'd0, fetch_cnt}, 32'd3);

        IRWrite  = 1'b0;
        PCSource = 2'b11;
        step();
        check("bad_pc",  PC, 32'hF0000123);
        check("bad_err", {31'd0, pc_src_err}, 32'h1);

        PCWrite = 1'b0;
        step();
        check("sticky_err", {31'd0, pc_src_err}, 32'h1);

        PCWrite   = 1'b1;
        PCSource  = 2'b00;
        ALUResult = 32'hFFFFFFFF;
        IRWrite   = 1'b1;
        MemData   = 32'h80000000;
        step();
        check("wrap_pc",     PC, 32'hFFFFFFFF);
        check("sticky_err2", {31'd0, pc_src_err}, 32'h1);
        check("beq_op",      {26'd0, Op}, 32'h20);

        reset = 1'b0;
        #1;
        check("async_pc",  PC, 32'h0);
        check("async_op",  {26'd0, Op}, 32'h0);
        check("async_cnt", {16'd0, fetch_cnt}, 32'h0);
        check("async_err", {31'd0, pc_src_err}, 32'h0);
        check("async_mdr", MDR, 32'h0);

        step();
        reset   = 1'b1;
        PCWrite = 1'b0;
        IRWrite = 1'b1;
        repeat (65535) step();
        check("cnt_max", {16'd0, fetch_cnt}, 32'h0000FFFF);
        step();
        check("cnt_wrap", {16'd0, fetch_cnt}, 32'h0);
        check("cnt_pc",   PC, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
